// File: rtl/prog_load_sched.sv
// prog_load_sched: buffers time/channel-value programming records from the
// RS232 command decoder and replays them to the sequential waveform generator
// as paced single-cycle strobes. Replay is held off while the generator is
// armed. Mode changes wait until every queued record has been delivered.
// Optional feature macro: LOAD_SCHED_OVF_CNT_EN enables the 8-bit saturating
// dropped-record counter on oOVF_CNT (tied to 0 otherwise).
module prog_load_sched #(
    parameter int BIT_NUM = 32,
    parameter int DEPTH   = 8,
    parameter int GAP_CYC = 3
) (
    input  logic                       CLK_50,
    input  logic                       nRst,
    input  logic [7:0]                 iMODE,
    input  logic                       iFLAG_TIME_READY,
    input  logic                       iFLAG_CH_VAL_READY,
    input  logic [7:0]                 iDATA_CHANNEL,
    input  logic [BIT_NUM-1:0]         iDATA_TIME,
    input  logic                       iDATA_CH_VAL,
    input  logic                       iARMED,
    input  logic                       iFLUSH,
    output logic [7:0]                 oMODE,
    output logic                       oFLAG_TIME_READY,
    output logic                       oFLAG_CH_VAL_READY,
    output logic [7:0]                 oDATA_CHANNEL,
    output logic [BIT_NUM-1:0]         oDATA_TIME,
    output logic                       oDATA_CH_VAL,
    output logic [$clog2(DEPTH):0]     oLEVEL,
    output logic                       oBUSY,
    output logic                       oOVF,
    output logic [7:0]                 oOVF_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 8 + BIT_NUM + 1;
    localparam int GW = $clog2(GAP_CYC + 1);
    // T_GAP lasts GAP_CYC cycles. V_GAP lasts GAP_CYC-1 cycles because the
    // IDLE cycle that looks at the FIFO is itself the last idle cycle after
    // the value strobe; this keeps back-to-back records 2+2*GAP_CYC apart.
    localparam logic [GW-1:0] T_GAP_LD = GW'(GAP_CYC - 1);
    localparam logic [GW-1:0] V_GAP_LD = GW'((GAP_CYC > 1) ? (GAP_CYC - 2) : 0);

    typedef enum logic [2:0] {IDLE, T_ISSUE, T_GAP, V_ISSUE, V_GAP} state_t;

    state_t               state;
    logic [GW-1:0]        gap_cnt;
    logic                 time_d, chv_d;
    logic                 time_vld_p0, chv_vld_p0;
    logic [BIT_NUM-1:0]   time_p0;
    logic [7:0]           ch_p0;
    logic                 val_p0;
    logic [BIT_NUM-1:0]   stage_time;
    logic [RW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        count;
    logic [7:0]           mode_pend;
    logic [BIT_NUM-1:0]   push_time;
    logic                 push, full, push_ok, drop, pop;

    // Stage p0: delayed flag copies and registered rising-edge strobes
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) begin
            time_d      <= 1'b0;
            chv_d       <= 1'b0;
            time_vld_p0 <= 1'b0;
            chv_vld_p0  <= 1'b0;
        end else begin
            time_d      <= iFLAG_TIME_READY;
            chv_d       <= iFLAG_CH_VAL_READY;
            time_vld_p0 <= iFLAG_TIME_READY & ~time_d;
            chv_vld_p0  <= iFLAG_CH_VAL_READY & ~chv_d;
        end
    end

    // Stage p0: decoder data travelling alongside the edge strobes
    always_ff @(posedge CLK_50) begin
        time_p0 <= iDATA_TIME;
        ch_p0   <= iDATA_CHANNEL;
        val_p0  <= iDATA_CH_VAL;
    end

    // Simultaneous edges use the fresh time word, otherwise the staged one
    assign push_time = time_vld_p0 ? time_p0 : stage_time;
    assign push      = chv_vld_p0 & ~iFLUSH;
    assign full      = (count == LW'(DEPTH));
    assign push_ok   = push & ~full;
    assign drop      = push & full;
    assign pop       = (state == IDLE) && (count != '0) && !iARMED && !iFLUSH;

    // Staging register for the most recent time word
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst)            stage_time <= '0;
        else if (iFLUSH)      stage_time <= '0;
        else if (time_vld_p0) stage_time <= time_p0;
    end

    // Stage p1: record storage write
    always_ff @(posedge CLK_50) begin
        if (push_ok) mem[wr_ptr] <= {ch_p0, push_time, val_p0};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (iFLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(push_ok) - LW'(pop);
        end
    end

    // Sticky overflow flag
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst)       oOVF <= 1'b0;
        else if (iFLUSH) oOVF <= 1'b0;
        else if (drop)   oOVF <= 1'b1;
    end

`ifdef LOAD_SCHED_OVF_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] ovf_cnt;

    // Saturating count of dropped records
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst)       ovf_cnt <= 8'd0;
        else if (iFLUSH) ovf_cnt <= 8'd0;
        else if (drop)   ovf_cnt <= sat_inc8(ovf_cnt);
    end

    assign oOVF_CNT = ovf_cnt;
`else
    assign oOVF_CNT = 8'd0;
`endif

    // Stage p2: drain FSM with registered strobes and output data
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) begin
            state              <= IDLE;
            gap_cnt            <= '0;
            oFLAG_TIME_READY   <= 1'b0;
            oFLAG_CH_VAL_READY <= 1'b0;
            oDATA_CHANNEL      <= 8'd0;
            oDATA_TIME         <= '0;
            oDATA_CH_VAL       <= 1'b0;
        end else if (iFLUSH) begin
            state              <= IDLE;
            gap_cnt            <= '0;
            oFLAG_TIME_READY   <= 1'b0;
            oFLAG_CH_VAL_READY <= 1'b0;
        end else begin
            oFLAG_TIME_READY   <= 1'b0;
            oFLAG_CH_VAL_READY <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        {oDATA_CHANNEL, oDATA_TIME, oDATA_CH_VAL} <= mem[rd_ptr];
                        oFLAG_TIME_READY <= 1'b1;
                        state            <= T_ISSUE;
                    end
                end
                T_ISSUE: begin
                    gap_cnt <= T_GAP_LD;
                    state   <= T_GAP;
                end
                T_GAP: begin
                    if (gap_cnt == '0) begin
                        oFLAG_CH_VAL_READY <= 1'b1;
                        state              <= V_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                V_ISSUE: begin
                    if (GAP_CYC > 1) begin
                        gap_cnt <= V_GAP_LD;
                        state   <= V_GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                V_GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mode deferral: release the pending mode only once everything is drained
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) begin
            mode_pend <= 8'd0;
            oMODE     <= 8'd0;
        end else begin
            mode_pend <= iMODE;
            if ((state == IDLE) && (count == '0) && !push) oMODE <= mode_pend;
        end
    end

    assign oLEVEL = count;
    assign oBUSY  = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_prog_load_sched.sv
// Testbench for prog_load_sched: directed scenarios plus randomized record
// traffic, checked against a queue-based model of the record stream.
module tb_prog_load_sched;
    localparam int BIT_NUM = 32;
    localparam int DEPTH   = 8;
    localparam int GAP     = 3;
    localparam int PERIOD  = 2 + 2 * GAP;

    logic                 CLK_50, nRst;
    logic [7:0]           iMODE;
    logic                 iFLAG_TIME_READY, iFLAG_CH_VAL_READY;
    logic [7:0]           iDATA_CHANNEL;
    logic [BIT_NUM-1:0]   iDATA_TIME;
    logic                 iDATA_CH_VAL, iARMED, iFLUSH;
    logic [7:0]           oMODE;
    logic                 oFLAG_TIME_READY, oFLAG_CH_VAL_READY;
    logic [7:0]           oDATA_CHANNEL;
    logic [BIT_NUM-1:0]   oDATA_TIME;
    logic                 oDATA_CH_VAL;
    logic [$clog2(DEPTH):0] oLEVEL;
    logic                 oBUSY, oOVF;
    logic [7:0]           oOVF_CNT;

    prog_load_sched #(.BIT_NUM(BIT_NUM), .DEPTH(DEPTH), .GAP_CYC(GAP)) dut (
        .CLK_50(CLK_50), .nRst(nRst), .iMODE(iMODE),
        .iFLAG_TIME_READY(iFLAG_TIME_READY), .iFLAG_CH_VAL_READY(iFLAG_CH_VAL_READY),
        .iDATA_CHANNEL(iDATA_CHANNEL), .iDATA_TIME(iDATA_TIME), .iDATA_CH_VAL(iDATA_CH_VAL),
        .iARMED(iARMED), .iFLUSH(iFLUSH), .oMODE(oMODE),
        .oFLAG_TIME_READY(oFLAG_TIME_READY), .oFLAG_CH_VAL_READY(oFLAG_CH_VAL_READY),
        .oDATA_CHANNEL(oDATA_CHANNEL), .oDATA_TIME(oDATA_TIME), .oDATA_CH_VAL(oDATA_CH_VAL),
        .oLEVEL(oLEVEL), .oBUSY(oBUSY), .oOVF(oOVF), .oOVF_CNT(oOVF_CNT)
    );

    typedef struct packed {
        logic [7:0]         ch;
        logic [BIT_NUM-1:0] t;
        logic               v;
    } rec_t;

    rec_t        q_exp[$];
    logic [31:0] stg;
    int          nvec, nerr, n_kept;
    int          cyc;
    bit          mon_en;
    int          t_cnt, v_cnt, last_t, last_v;

    initial CLK_50 = 1'b0;
    always #10 CLK_50 = ~CLK_50;
    always @(posedge CLK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge CLK_50);
    endtask

    // kind 0: time edge then ch-val edge; 1: both edges together;
    // 2: ch-val edge only (reuses staged time); 3: time edge only
    task automatic send_rec(input int kind, input logic [31:0] t, input logic [7:0] ch,
                            input logic v, input bit keep);
        rec_t r;
        case (kind)
            0: begin
                tick(); iDATA_TIME = t; iFLAG_TIME_READY = 1'b1;
                tick(); iFLAG_TIME_READY = 1'b0; iDATA_CHANNEL = ch; iDATA_CH_VAL = v;
                iFLAG_CH_VAL_READY = 1'b1;
                tick(); iFLAG_CH_VAL_READY = 1'b0;
                stg = t;
            end
            1: begin
                tick(); iDATA_TIME = t; iDATA_CHANNEL = ch; iDATA_CH_VAL = v;
                iFLAG_TIME_READY = 1'b1; iFLAG_CH_VAL_READY = 1'b1;
                tick(); iFLAG_TIME_READY = 1'b0; iFLAG_CH_VAL_READY = 1'b0;
                stg = t;
            end
            2: begin
                tick(); iDATA_TIME = t; iDATA_CHANNEL = ch; iDATA_CH_VAL = v;
                iFLAG_CH_VAL_READY = 1'b1;
                tick(); iFLAG_CH_VAL_READY = 1'b0;
            end
            default: begin
                tick(); iDATA_TIME = t; iFLAG_TIME_READY = 1'b1;
                tick(); iFLAG_TIME_READY = 1'b0;
                stg = t;
            end
        endcase
        if (kind != 3 && keep) begin
            r.ch = ch; r.t = stg; r.v = v;
            q_exp.push_back(r);
            n_kept++;
        end
    endtask

    task automatic wait_t(input int target, input int bound, input string tag);
        for (int i = 0; i < bound && t_cnt < target; i++) tick();
        chk(tag, t_cnt >= target, 1);
    endtask

    task automatic wait_v(input int target, input int bound, input string tag);
        for (int i = 0; i < bound && v_cnt < target; i++) tick();
        chk(tag, v_cnt >= target, 1);
    endtask

    // Record-stream scoreboard: order, contents and strobe spacing
    initial begin
        rec_t cur;
        bit   v_pend;
        int   v_due;
        v_pend = 1'b0;
        v_due  = 0;
        cur    = '0;
        forever begin
            @(negedge CLK_50);
            if (mon_en) begin
                if (oFLAG_TIME_READY) begin
                    t_cnt++;
                    chk("t_avail", q_exp.size() > 0, 1);
                    if (q_exp.size() > 0) begin
                        cur = q_exp.pop_front();
                        chk("t_time", oDATA_TIME, cur.t);
                        chk("t_ch", oDATA_CHANNEL, cur.ch);
                    end
                    if (t_cnt > 1) chk("t_period", (cyc - last_t) >= PERIOD, 1);
                    last_t = cyc;
                    v_pend = 1'b1;
                    v_due  = cyc + GAP + 1;
                end
                if (v_pend && cyc == v_due) begin
                    chk("v_strobe", oFLAG_CH_VAL_READY, 1);
                    chk("v_val", oDATA_CH_VAL, cur.v);
                    chk("v_ch", oDATA_CHANNEL, cur.ch);
                    v_pend = 1'b0;
                    v_cnt++;
                    last_v = cyc;
                end else if (oFLAG_CH_VAL_READY) begin
                    chk("v_unexp", oFLAG_CH_VAL_READY, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ns, t0, base_t, base_v;
        bit   seen;
        logic [7:0] ovf_exp;
        nRst = 1'b0; iMODE = 8'd0; iFLAG_TIME_READY = 1'b0; iFLAG_CH_VAL_READY = 1'b0;
        iDATA_CHANNEL = 8'd0; iDATA_TIME = '0; iDATA_CH_VAL = 1'b0; iARMED = 1'b0;
        iFLUSH = 1'b0; mon_en = 1'b0; stg = '0; nvec = 0; nerr = 0; n_kept = 0;
        t_cnt = 0; v_cnt = 0; last_t = 0; last_v = 0;
        tick(); tick();
        chk("rst_outs", {oMODE, oFLAG_TIME_READY, oFLAG_CH_VAL_READY, oDATA_CHANNEL,
                         oDATA_CH_VAL, oLEVEL, oBUSY, oOVF, oOVF_CNT}, 0);
        chk("rst_time", oDATA_TIME, 0);
        #5 nRst = 1'b1;
        tick(); tick();

        // single record with exact latencies
        send_rec(0, 32'h0000_1234, 8'd5, 1'b1, 1'b0);
        tick();
        chk("single_level_push", oLEVEL, 1);
        tick();
        chk("single_tstrobe", oFLAG_TIME_READY, 1);
        chk("single_time", oDATA_TIME, 32'h1234);
        chk("single_ch", oDATA_CHANNEL, 5);
        chk("single_level_pop", oLEVEL, 0);
        chk("single_busy", oBUSY, 1);
        seen = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            tick();
            seen = seen | oFLAG_CH_VAL_READY | oFLAG_TIME_READY;
        end
        chk("single_gap_quiet", seen, 0);
        tick();
        chk("single_vstrobe", oFLAG_CH_VAL_READY, 1);
        chk("single_val", oDATA_CH_VAL, 1);
        repeat (4) tick();
        chk("single_idle", {oBUSY, oLEVEL}, 0);

        // overflow while armed, then in-order paced replay
        iARMED = 1'b1;
        tick();
        for (int i = 0; i < 10; i++)
            send_rec(1, 32'h100 + i, 8'(i + 16), i[0], i < DEPTH);
        repeat (3) tick();
        chk("ovf_level", oLEVEL, DEPTH);
        chk("ovf_flag", oOVF, 1);
`ifdef LOAD_SCHED_OVF_CNT_EN
        ovf_exp = 8'd2;
`else
        ovf_exp = 8'd0;
`endif
        chk("ovf_cnt", oOVF_CNT, ovf_exp);
        base_t = t_cnt;
        mon_en = 1'b1;
        iARMED = 1'b0;
        wait_t(base_t + 1, 20, "ovf_first");
        t0 = last_t;
        wait_t(base_t + DEPTH, 120, "ovf_all");
        chk("ovf_span", last_t - t0, (DEPTH - 1) * PERIOD);
        wait_v(n_kept, 40, "ovf_drain");
        chk("ovf_sticky", oOVF, 1);

        // mode deferral behind three queued records
        iARMED = 1'b1;
        for (int i = 0; i < 3; i++) send_rec(1, 32'h200 + i, 8'(i + 40), 1'b1, 1'b1);
        repeat (3) tick();
        iMODE = 8'h05;
        repeat (4) tick();
        chk("mode_hold", oMODE, 8'h00);
        iARMED = 1'b0;
        wait_v(n_kept, 60, "mode_drain");
        for (int i = 0; i < 20 && oMODE != 8'h05; i++) tick();
        chk("mode_value", oMODE, 8'h05);
        chk("mode_delay", cyc - last_v, GAP + 1);

        // arm raised during T_GAP: current record completes, next one waits
        base_t = t_cnt;
        base_v = v_cnt;
        send_rec(1, 32'h300, 8'd60, 1'b0, 1'b1);
        send_rec(1, 32'h301, 8'd61, 1'b1, 1'b1);
        wait_t(base_t + 1, 20, "arm_first");
        tick();
        iARMED = 1'b1;
        wait_v(base_v + 1, 20, "arm_vfires");
        repeat (20) tick();
        chk("arm_hold", t_cnt, base_t + 1);
        chk("arm_level", oLEVEL, 1);
        iARMED = 1'b0;
        wait_v(n_kept, 40, "arm_release");

        // flush during T_GAP
        mon_en = 1'b0;
        send_rec(1, 32'h400, 8'd70, 1'b1, 1'b0);
        send_rec(1, 32'h401, 8'd71, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !oFLAG_TIME_READY; i++) tick();
        chk("flush_tstrobe", oFLAG_TIME_READY, 1);
        tick(); tick();
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
        stg = '0;
        chk("flush_level", oLEVEL, 0);
        chk("flush_ovf", oOVF, 0);
        chk("flush_ovf_cnt", oOVF_CNT, 0);
        ns = 0;
        repeat (12) begin
            tick();
            ns += int'(oFLAG_TIME_READY) + int'(oFLAG_CH_VAL_READY);
        end
        chk("flush_nostrobe", ns, 0);
        chk("flush_idle", oBUSY, 0);

        // ch-val edge without time edge after flush uses the cleared staging
        mon_en = 1'b1;
        send_rec(2, 32'hDEAD_BEEF, 8'h33, 1'b1, 1'b1);
        wait_v(n_kept, 30, "stage_clear");

        // asynchronous reset mid-record
        mon_en = 1'b0;
        send_rec(1, 32'h5555, 8'h44, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !oFLAG_TIME_READY; i++) tick();
        tick();
        #5 nRst = 1'b0;
        #1;
        chk("arst_outs", {oMODE, oFLAG_TIME_READY, oFLAG_CH_VAL_READY, oDATA_CHANNEL,
                          oDATA_CH_VAL, oLEVEL, oBUSY, oOVF, oOVF_CNT}, 0);
        chk("arst_time", oDATA_TIME, 0);
        stg = '0;
        tick(); tick();
        #5 nRst = 1'b1;
        ns = 0;
        repeat (10) begin
            tick();
            ns += int'(oFLAG_TIME_READY) + int'(oFLAG_CH_VAL_READY);
        end
        chk("arst_nostrobe", ns, 0);

        // randomized record traffic
        mon_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int kind, gap;
            for (int k = 0; k < 200 && q_exp.size() >= 6; k++) tick();
            kind = int'($urandom_range(0, 3));
            send_rec(kind, $urandom, 8'($urandom), 1'($urandom), 1'b1);
            gap = int'($urandom_range(0, 6));
            for (int g = 0; g < gap; g++) begin
                tick();
                iDATA_TIME = $urandom;
                iDATA_CHANNEL = 8'($urandom);
            end
        end
        wait_v(n_kept, 800, "rand_drain");
        repeat (6) tick();
        chk("final_idle", {oBUSY, oLEVEL}, 0);
        chk("final_q_empty", q_exp.size(), 0);
        chk("final_counts", t_cnt, v_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
